// File: rtl/fibonacci_checker_if.sv
// Term stream into the Fibonacci checker.
// Handshake: a term transfers on a rising clock edge where i_valid && o_ready;
// the source holds i_data stable while i_valid is high, and o_ready may drop
// at any time (it is low while the checker is being cleared).
interface fibonacci_checker_if #(
    parameter int WIDTH = 64
);
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_ready;

    modport master (output i_valid, output i_data, input o_ready);
    modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/fibonacci_checker.sv
// Streaming Fibonacci sequence checker: compares each accepted term with the
// sum of the two previous terms, reports pass/fail one cycle later, and keeps
// a sticky first-error record plus a sticky overflow flag.
module fibonacci_checker #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_seed_mode,
    fibonacci_checker_if.slave  s_if,
    output logic                o_chk_valid,
    output logic                o_chk_ok,
    output logic                o_error,
    output logic [CNT_W-1:0]    o_err_index,
    output logic [WIDTH-1:0]    o_err_got,
    output logic                o_overflow,
    output logic [CNT_W-1:0]    o_count,
    output logic [2:0]          o_state
);

    localparam logic [2:0] S_T0  = 3'd0;
    localparam logic [2:0] S_T1  = 3'd1;
    localparam logic [2:0] S_RUN = 3'd2;
    localparam logic [2:0] S_ERR = 3'd3;
    localparam logic [2:0] S_OVF = 3'd4;

    localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

    logic [2:0]       r_state;
    logic             r_mode;
    logic [WIDTH-1:0] r_prev1;
    logic [WIDTH-1:0] r_prev2;
    logic [WIDTH:0]   r_exp;
    logic             r_chk_valid;
    logic             r_chk_ok;
    logic             r_error;
    logic [CNT_W-1:0] r_err_index;
    logic [WIDTH-1:0] r_err_got;
    logic             r_overflow;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH:0]   w_next_sum;
    logic             w_ok;
    logic [CNT_W-1:0] w_count_inc;

    // Clear blocks acceptance so a term presented during clear is never lost silently.
    assign s_if.o_ready = !i_clear;
    assign w_accept     = s_if.i_valid && !i_clear;
    assign w_data       = s_if.i_data;
    // Sum after shifting the new term in: new prev1 = data, new prev2 = old prev1.
    assign w_next_sum   = {1'b0, r_prev1} + {1'b0, w_data};
    assign w_count_inc  = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;

    // Per-state verdict for the term currently presented; a wrapped sum never matches.
    always_comb begin
        w_ok = 1'b0;
        case (r_state)
            S_T0:    w_ok = i_seed_mode || (w_data == L_ONE);
            S_T1:    w_ok = r_mode || (w_data == L_ONE);
            S_RUN:   w_ok = !r_exp[WIDTH] && (w_data == r_exp[WIDTH-1:0]);
            default: w_ok = 1'b0;
        endcase
    end

    // Checker state, history registers, result pulse and sticky status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_T0;
            r_mode      <= 1'b0;
            r_prev1     <= '0;
            r_prev2     <= '0;
            r_exp       <= '0;
            r_chk_valid <= 1'b0;
            r_chk_ok    <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_err_got   <= '0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
        end else if (i_clear) begin
            r_state     <= S_T0;
            r_mode      <= 1'b0;
            r_prev1     <= '0;
            r_prev2     <= '0;
            r_exp       <= '0;
            r_chk_valid <= 1'b0;
            r_chk_ok    <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_err_got   <= '0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_chk_valid <= 1'b0;
            r_chk_ok    <= 1'b0;
            // S_ERR and S_OVF swallow terms without reporting or counting them.
            if (w_accept && (r_state == S_T0 || r_state == S_T1 || r_state == S_RUN)) begin
                r_chk_valid <= 1'b1;
                r_chk_ok    <= w_ok;
                r_count     <= w_count_inc;
                if (!w_ok) begin
                    if (!r_error) begin
                        r_error     <= 1'b1;
                        r_err_index <= r_count;
                        r_err_got   <= w_data;
                    end
                    r_state <= S_ERR;
                end
                case (r_state)
                    S_T0: begin
                        r_mode  <= i_seed_mode;
                        r_prev1 <= w_data;
                        if (w_ok) r_state <= S_T1;
                    end
                    S_T1: begin
                        r_prev2 <= r_prev1;
                        r_prev1 <= w_data;
                        r_exp   <= w_next_sum;
                        if (w_ok) begin
                            if (w_next_sum[WIDTH]) begin
                                r_overflow <= 1'b1;
                                r_state    <= S_OVF;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    default: begin
                        if (w_ok) begin
                            r_prev2 <= r_prev1;
                            r_prev1 <= w_data;
                            r_exp   <= w_next_sum;
                            if (w_next_sum[WIDTH]) begin
                                r_overflow <= 1'b1;
                                r_state    <= S_OVF;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_chk_valid = r_chk_valid;
    assign o_chk_ok    = r_chk_ok;
    assign o_error     = r_error;
    assign o_err_index = r_err_index;
    assign o_err_got   = r_err_got;
    assign o_overflow  = r_overflow;
    assign o_count     = r_count;
    assign o_state     = r_state;

endmodule
